// File: rtl/tx_sr_8_msb_framer.sv
// Byte-to-serial framer: start bit 0, eight data bits MSB first, stop bit 1,
// each bit held CLKS_PER_BIT clocks; every output comes straight from a flop.
module tx_sr_8_msb_framer #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           r_state;
  state_t           w_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift;
  logic             r_serial;
  logic             w_serial;
  logic             r_busy;
  logic             w_busy;
  logic             r_done;
  logic             w_done;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);

  // Next-state and next-output values; outputs are the registered copies.
  always_comb begin
    w_state   = r_state;
    w_cnt     = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    w_bit_idx = r_bit_idx;
    w_shift   = r_shift;
    w_serial  = r_serial;
    w_busy    = r_busy;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt    = '0;
        w_serial = 1'b1;
        w_busy   = 1'b0;
        if (tx_start) begin
          w_state  = START;
          w_shift  = tx_data;
          w_serial = 1'b0;
          w_busy   = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state   = DATA;
          w_bit_idx = 3'd7;
          w_serial  = r_shift[7];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift = {r_shift[6:0], 1'b1};
          if (r_bit_idx == 3'd0) begin
            w_state  = STOP;
            w_serial = 1'b1;
          end else begin
            w_bit_idx = r_bit_idx - 3'd1;
            w_serial  = r_shift[6];
          end
        end
      end
      STOP: begin
        w_serial = 1'b1;
        if (w_bit_end) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end
      default: begin
        w_state  = IDLE;
        w_cnt    = '0;
        w_serial = 1'b1;
        w_busy   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'hFF;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit_idx <= w_bit_idx;
      r_shift   <= w_shift;
      r_serial  <= w_serial;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign serial_out = r_serial;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_tx_sr_8_msb_framer.sv
// Bench for tx_sr_8_msb_framer: frames on a 10-clock-per-bit and a 1-clock-per-bit
// instance are compared cycle by cycle against a bit-position model of the frame.
module tb_tx_sr_8_msb_framer;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       so10, busy10, done10;
  logic       so1, busy1, done1;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  tx_sr_8_msb_framer #(.CLKS_PER_BIT(10)) u_dut10 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .serial_out(so10), .tx_busy(busy10), .tx_done(done10)
  );

  tx_sr_8_msb_framer #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .serial_out(so1), .tx_busy(busy1), .tx_done(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int cpb,
                         input logic es, input logic eb, input logic ed);
    if (cpb == 1) begin
      chk({tag, " serial_out"}, so1, es);
      chk({tag, " tx_busy"}, busy1, eb);
      chk({tag, " tx_done"}, done1, ed);
    end else begin
      chk({tag, " serial_out"}, so10, es);
      chk({tag, " tx_busy"}, busy10, eb);
      chk({tag, " tx_done"}, done10, ed);
    end
  endtask

  // Line level in cycle k (1-based after the accepting edge): slot 0 start, 1..8 data MSB first, then high.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input int cpb);
    int j;
    j = (k - 1) / cpb;
    if (j == 0) return 1'b0;
    if (j <= 8) return d[8-j];
    return 1'b1;
  endfunction

  // mode 0: clean, 1: random tx_start/tx_data while busy, 2: tx_start held high,
  // 3: tx_start pulse at cycle 35 with tx_data forced to 0xFF.
  task automatic run_frame(input logic [7:0] d, input int mode, input int cpb, input int abort_at);
    int last;
    last = 10 * cpb + 1;
    tx_start = 1'b1;
    tx_data  = d;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      case (mode)
        1: begin
          tx_start = 1'($urandom_range(0, 1));
          tx_data  = 8'($urandom);
        end
        2: tx_start = 1'b1;
        3: begin
          tx_start = (k == 35);
          tx_data  = 8'hFF;
        end
        default: tx_start = 1'b0;
      endcase
      if (k == last) tx_start = (mode == 2);
      chk_out($sformatf("frame %02h cpb=%0d k=%0d", d, cpb, k), cpb,
              exp_bit(d, k, cpb), k < last, k == last);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk_out($sformatf("abort %02h k=%0d", d, k), cpb, 1'b1, 1'b0, 1'b0);
        break;
      end
    end
  endtask

  task automatic idle(input int n, input int cpb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_start = 1'b0;
      chk_out($sformatf("idle cpb=%0d", cpb), cpb, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         gap;

    // Power-on: reset with a pending start request
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk_out("por", 10, 1'b1, 1'b0, 1'b0);
      chk_out("por", 1, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk_out("por release", 10, 1'b1, 1'b0, 1'b0);
    run_frame(8'h00, 0, 10, 0);
    idle(1, 10);

    run_frame(8'hA5, 0, 10, 0);
    idle(2, 10);

    run_frame(8'h00, 3, 10, 0);
    idle(1, 10);

    // Back-to-back with tx_start held high
    run_frame(8'h3C, 2, 10, 0);
    run_frame(8'hC3, 2, 10, 0);
    tx_start = 1'b0;
    idle(1, 10);

    repeat (5) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      run_frame(d, $urandom_range(0, 1), 10, 0);
      tx_start = 1'b0;
      idle(gap, 10);
    end

    // Reset mid-frame, then a fresh frame after release
    run_frame(8'h0F, 0, 10, 47);
    tx_start = 1'b1;
    tx_data  = 8'h81;
    repeat (2) begin
      @(negedge clk);
      chk_out("rst hold", 10, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    run_frame(8'h81, 0, 10, 0);
    idle(1, 10);

    // One clock per bit
    rst = 1'b1;
    @(negedge clk);
    chk_out("rst cpb1", 1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    run_frame(8'h01, 0, 1, 0);
    idle(1, 1);
    run_frame(8'h5A, 2, 1, 0);
    run_frame(8'hA5, 2, 1, 0);
    tx_start = 1'b0;
    idle(2, 1);
    repeat (6) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 2);
      run_frame(d, $urandom_range(0, 1), 1, 0);
      tx_start = 1'b0;
      idle(gap, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sr_8_msb_framer.md
TX_SR_8_MSB_FRAMER -- requirements
Module: tx_sr_8_msb_framer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit (legal range 1..1023).
REQ-002 The block SHALL have port clk  input  1  meaning system clock, rising-edge active.
REQ-003 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port tx_start  input  1  meaning request to send tx_data, sampled on rising clk.
REQ-005 The block SHALL have port tx_data  input  8  meaning parallel byte to serialize, MSB transmitted first.
REQ-006 The block SHALL have port serial_out  output  1  meaning serial line, idle/inactive value 1.
REQ-007 The block SHALL have port tx_busy  output  1  meaning a frame is in progress.
REQ-008 The block SHALL have port tx_done  output  1  meaning single-cycle frame-complete pulse.

Function
REQ-009 The frame SHALL be: start bit 0, tx_data[7] down to tx_data[0], stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame length 10*CLKS_PER_BIT cycles.
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP; all outputs registered (no combinational path input->output).
REQ-011 IDLE: serial_out=1, tx_busy=0; tx_start=1 at a rising edge SHALL capture tx_data into an internal 8-bit shift register and move to START at that edge.
REQ-012 Latency: serial_out SHALL go 0 and tx_busy 1 in the first cycle after the accepting edge.
REQ-013 START: after CLKS_PER_BIT cycles -> DATA with bit index 7.
REQ-014 DATA: serial_out SHALL equal the captured shift register MSB; every CLKS_PER_BIT cycles shift left by one (fill 1); after 8 bits -> STOP.
REQ-015 STOP: serial_out=1 for CLKS_PER_BIT cycles, then -> IDLE.
REQ-016 tx_done SHALL be 1 for exactly the one cycle following the last STOP cycle (first IDLE cycle), otherwise 0; tx_busy is 0 in that cycle.
REQ-017 tx_start while tx_busy=1 SHALL be ignored (no queuing, no effect on current frame).
REQ-018 tx_start=1 in the tx_done cycle SHALL be accepted, giving back-to-back frames with exactly 1 idle-high cycle between stop bit and next start bit.
REQ-019 Changes on tx_data after the accepting edge SHALL not affect the frame in progress.
REQ-020 Bit-period counter SHALL be $clog2(CLKS_PER_BIT)+1 bits, count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; CLKS_PER_BIT=1 SHALL yield one cycle per bit.
REQ-021 tx_start held high continuously SHALL start a new frame at each tx_done cycle only.

Reset
REQ-022 rst=1 SHALL immediately (without clk) force state IDLE, serial_out=1, tx_busy=0, tx_done=0, counters and shift register to 0xFF/0.
REQ-023 rst asserted mid-frame SHALL abort the frame; no tx_done pulse for the aborted frame.
REQ-024 While rst=1, tx_start SHALL be ignored; first acceptance possible at the first rising edge after rst release.

Verification (CLKS_PER_BIT=10 unless stated)
REQ-025 Power-on: rst=1 with tx_start=1, tx_data=0x00 for 2 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout and after release.
REQ-026 Single frame: tx_data=0xA5, tx_start pulse -> serial_out 0,1,0,1,0,0,1,0,1,1 each for 10 cycles; tx_done single pulse in cycle 101 after accept edge.
REQ-027 Busy ignore: send 0x00, pulse tx_start with tx_data=0xFF at cycle 35 and change tx_data -> frame bits remain all 0; exactly one tx_done.
REQ-028 Back-to-back: tx_start held high, tx_data=0x3C then 0xC3 -> two frames, one idle-high cycle between, two tx_done pulses 101 cycles apart.
REQ-029 Reset mid-frame: assert rst at cycle 47 of a 0x0F frame, between clock edges -> serial_out=1 within same cycle, no tx_done; new 0x81 frame after release transmits correctly.
REQ-030 CLKS_PER_BIT=1: tx_data=0x01 -> serial_out 0,0,0,0,0,0,0,0,1,1 on consecutive cycles; tx_done on cycle 11.
